execute_pipe: RTL and testbench
===============================

Name: execute_pipe

Overview:
- Parametrised EX stage: operand select, ALU evaluate, one-cycle registered result, valid/ready handshakes both sides.
- Tracks up to STORE_HIST_DEPTH recently issued stores with per-entry lifetime.
- Holds any load whose byte range overlaps a live store; emits bubbles meanwhile.
- Sits between decode/regread and the memory stage.

Parameters:
- XLEN, 32, datapath width for operands, imm, result, addresses.
- STORE_HIST_DEPTH, 4, store-history entries (>=1).
- HIST_LIFETIME, 3, cycles a store stays live after acceptance (>=1); matches memory write-commit latency.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  EX can accept this cycle
- flush_i  in  1  kill output-register contents; blocks acceptance this cycle
- sel_rd_i  in  5  destination register
- alu_op_i  in  alu_op_e  ALU operation
- alu_src1_i, alu_src2_i  in  alu_src_e  operand selects (IMM/RS1/RS2, other -> 0)
- mem_re_i, mem_we_i  in  1  load / store
- mem_size_i  in  data_size_e  access size
- imm_i, rs1_i, rs2_i  in  XLEN  operands
- valid_o  out  1  output register holds an instruction
- ready_i  in  1  downstream accepts
- sel_rd_o, mem_re_o, mem_we_o, mem_size_o, rs2_o, alu_result_o  out  registered copies; alu_result_o XLEN
- hazard_o  out  1  combinational: load held by store overlap

Behaviour:
- Reset:
  - All outputs, registers and history cleared.
  - valid_o=0, alu_result_o=0, mem_size_o=0.
  - Write pointer 0; all lifetimes 0.
- Operand mux and ALU are combinational on inputs; result is the load/store address for memory ops.
- hazard = valid_i & mem_re_i & overlap with any live entry.
  - Overlap test: byte range [addr, addr+bytes(size)) intersects entry range.
  - bytes: BYTE=1, HALF=2, WORD=4.
  - Address arithmetic is XLEN+1 bits; no wrap aliasing.
- full = entry at write pointer live.
- ready_o = !flush_i & !hazard & !(mem_we_i & full) & (!valid_o | ready_i).
- accept = valid_i & ready_o. On accept:
  - Output registers load from inputs.
  - valid_o <= 1.
  - Latency exactly 1 cycle.
- No accept and ready_i=1: valid_o <= 0; payload regs hold their last value.
- No accept and ready_i=0: all output regs hold (stable under backpressure).
- flush_i: valid_o <= 0 next cycle regardless of ready_i. History is not cleared (issued stores are committed).
- History, per cycle:
  - Every live entry lifetime decrements by 1.
  - Accepted store writes the entry at the write pointer: addr, size, lifetime=HIST_LIFETIME.
  - Write pointer increments, wrapping STORE_HIST_DEPTH-1 -> 0.
  - Insert and decrement in the same cycle: insert wins for that entry.
- Equal lifetimes mean in-order expiry, so the oldest entry sits at the write pointer.
- Load accepted in the same cycle a store is written: the load compares only entries live before that cycle.
- A load stalls only on overlap. A store stalls only when full. No other stall sources.
- Reset asserted mid-operation clears everything asynchronously; no partial state is retained.

Optional Feature:
- Macro EXEC_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o (32 bits), reset 0.
  - Increments each cycle valid_i=1 and accept=0.
  - Saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds alu_op_e, alu_src_e, data_size_e, and a function size_bytes(data_size_e) returning 1/2/4.
- One natural sub-module, store_hist: history array, pointer, lifetimes, overlap compare.
  - Inputs: push, addr, size, query addr/size.
  - Outputs: hit, full.
- Existing alu module instantiated unchanged.

Test Plan:
1. ADD, rs1=5, rs2=7, valid_i=1, ready_i=1 -> next cycle valid_o=1, alu_result_o=12, sel_rd_o echoed.
2. SW to 0x100, then LW from 0x100 on the next cycle (HIST_LIFETIME=3) -> hazard_o=1, ready_o=0 and valid_o=0 for 2 cycles. Load accepted in the 3rd cycle; result 0x100 appears the cycle after.
3. SB to 0x103, then LH from 0x102 -> stall. SB to 0x103, then LH from 0x100 -> no stall (no overlap).
4. DEPTH=4, lifetime=8, five back-to-back SW -> 5th sees ready_o=0 until entry 0 expires; pointer wraps to 0.
5. ready_i=0 for 3 cycles with valid_o=1 -> outputs stable, ready_o=0. flush_i=1 -> valid_o=0 next cycle; prior store entry still blocks an overlapping load.
6. Assert rst_n low while a load is stalled -> all outputs 0 and history empty; the load reissued after reset is accepted immediately. With EXEC_STALL_CNT_EN defined, scenario 2 gives stall_cnt_o=2.

Source files
------------

// File: rtl/execute_pipe_pkg.sv
// Shared types for the execute stage: ALU ops, operand selects, access sizes.
// Optional stall counter on the top is enabled with EXEC_STALL_CNT_EN.
package execute_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_IMM,
    SRC_RS1,
    SRC_RS2
  } alu_src_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } data_size_e;

  function automatic logic [2:0] size_bytes(
    data_size_e sz
  );
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/execute_pipe_if.sv
// Decode-to-EX and EX-to-MEM handshake bundle.
// slave is the EX stage view, master the surrounding pipeline.
interface execute_pipe_if #(
  parameter int XLEN = 32
);
  import execute_pipe_pkg::*;

  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic [4:0]      sel_rd_i;
  alu_op_e         alu_op_i;
  alu_src_e        alu_src1_i;
  alu_src_e        alu_src2_i;
  logic            mem_re_i;
  logic            mem_we_i;
  data_size_e      mem_size_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;

  logic            valid_o;
  logic            ready_i;
  logic [4:0]      sel_rd_o;
  logic            mem_re_o;
  logic            mem_we_o;
  data_size_e      mem_size_o;
  logic [XLEN-1:0] rs2_o;
  logic [XLEN-1:0] alu_result_o;
  logic            hazard_o;

  modport slave (
    input  valid_i, flush_i, sel_rd_i,
    input  alu_op_i, alu_src1_i, alu_src2_i,
    input  mem_re_i, mem_we_i, mem_size_i,
    input  imm_i, rs1_i, rs2_i, ready_i,
    output ready_o, valid_o, sel_rd_o,
    output mem_re_o, mem_we_o, mem_size_o,
    output rs2_o, alu_result_o, hazard_o
  );

  modport master (
    output valid_i, flush_i, sel_rd_i,
    output alu_op_i, alu_src1_i, alu_src2_i,
    output mem_re_i, mem_we_i, mem_size_i,
    output imm_i, rs1_i, rs2_i, ready_i,
    input  ready_o, valid_o, sel_rd_o,
    input  mem_re_o, mem_we_o, mem_size_o,
    input  rs2_o, alu_result_o, hazard_o
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU shared by the execute stage.
// Shift amounts use the low log2(XLEN) bits of b.
module alu
  import execute_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;
  logic           lt_s;
  logic           lt_u;

  assign sh   = b[SHW-1:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << sh;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/execute_pipe_store_hist.sv
// Ring of recently issued stores with per-entry lifetime and
// byte-range overlap query for loads.
module store_hist
  import execute_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int LIFETIME = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] addr,
  input  data_size_e      size,
  input  logic [XLEN-1:0] q_addr,
  input  data_size_e      q_size,
  output logic            hit,
  output logic            full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LIFETIME > 1) ? $clog2(LIFETIME) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  // The acceptance cycle is the first live cycle, so the
  // counter holds only the cycles remaining after it.
  localparam logic [LW-1:0] LIFE_INIT = LW'(LIFETIME - 1);

  logic [XLEN-1:0] addr_q [DEPTH];
  data_size_e      size_q [DEPTH];
  logic [LW-1:0]   life_q [DEPTH];
  logic [PW-1:0]   wptr;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] ovl;
  logic [XLEN:0]    q_lo;
  logic [XLEN:0]    q_hi;

  assign q_lo = {1'b0, q_addr};
  assign q_hi = q_lo + (XLEN+1)'(size_bytes(q_size));

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [XLEN:0] lo;
    logic [XLEN:0] hi;
    assign lo      = {1'b0, addr_q[g]};
    assign hi      = lo + (XLEN+1)'(size_bytes(size_q[g]));
    assign live[g] = life_q[g] != '0;
    assign ovl[g]  = live[g] & (q_lo < hi) & (lo < q_hi);
  end

  assign hit  = |ovl;
  assign full = live[wptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        size_q[i] <= SZ_BYTE;
        life_q[i] <= '0;
      end
      wptr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wptr == PW'(i)) begin
          addr_q[i] <= addr;
          size_q[i] <= size;
          life_q[i] <= LIFE_INIT;
        end else if (life_q[i] != '0) begin
          life_q[i] <= life_q[i] - 1'b1;
        end
      end
      if (push) begin
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_pipe.sv
// EX stage: operand select, ALU, registered result, store-load hazard hold.
// EXEC_STALL_CNT_EN adds a saturating stall_cnt_o output.
module execute_pipe
  import execute_pipe_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int STORE_HIST_DEPTH = 4,
  parameter int HIST_LIFETIME    = 3
) (
  input logic clk,
  input logic rst_n,
  execute_pipe_if.slave bus
`ifdef EXEC_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] result;
  logic            hit;
  logic            full;
  logic            hazard;
  logic            ready;
  logic            accept;
  logic            push;

  logic            valid_q;
  logic [4:0]      rd_q;
  logic            re_q;
  logic            we_q;
  data_size_e      size_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] res_q;

  always_comb begin
    op1 = '0;
    unique case (1'b1)
      bus.alu_src1_i == SRC_IMM: op1 = bus.imm_i;
      bus.alu_src1_i == SRC_RS1: op1 = bus.rs1_i;
      bus.alu_src1_i == SRC_RS2: op1 = bus.rs2_i;
      default:                   op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    unique case (1'b1)
      bus.alu_src2_i == SRC_IMM: op2 = bus.imm_i;
      bus.alu_src2_i == SRC_RS1: op2 = bus.rs1_i;
      bus.alu_src2_i == SRC_RS2: op2 = bus.rs2_i;
      default:                   op2 = '0;
    endcase
  end

  alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op(bus.alu_op_i),
    .a (op1),
    .b (op2),
    .y (result)
  );

  // Query sees only registered history, so a store written
  // this cycle never affects a load decided this cycle.
  store_hist #(
    .XLEN    (XLEN),
    .DEPTH   (STORE_HIST_DEPTH),
    .LIFETIME(HIST_LIFETIME)
  ) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .addr  (result),
    .size  (bus.mem_size_i),
    .q_addr(result),
    .q_size(bus.mem_size_i),
    .hit   (hit),
    .full  (full)
  );

  assign hazard = bus.valid_i & bus.mem_re_i & hit;
  assign ready  = !bus.flush_i & !hazard
                & !(bus.mem_we_i & full)
                & (!valid_q | bus.ready_i);
  assign accept = bus.valid_i & ready;
  assign push   = accept & bus.mem_we_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      rs2_q   <= '0;
      res_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      rd_q    <= bus.sel_rd_i;
      re_q    <= bus.mem_re_i;
      we_q    <= bus.mem_we_i;
      size_q  <= bus.mem_size_i;
      rs2_q   <= bus.rs2_i;
      res_q   <= result;
    end else if (bus.flush_i || bus.ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.hazard_o     = hazard;
  assign bus.valid_o      = valid_q;
  assign bus.sel_rd_o     = rd_q;
  assign bus.mem_re_o     = re_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_size_o   = size_q;
  assign bus.rs2_o        = rs2_q;
  assign bus.alu_result_o = res_q;

`ifdef EXEC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (bus.valid_i && !accept && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: vector table plus scoreboard,
// with hand sequences for stalls, backpressure, flush and reset.
module tb_execute_pipe;
  import execute_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic sel8 = 1'b0;

  execute_pipe_if #(.XLEN(32)) bus ();
  execute_pipe_if #(.XLEN(32)) bus8 ();

  assign bus8.valid_i    = bus.valid_i;
  assign bus8.flush_i    = bus.flush_i;
  assign bus8.sel_rd_i   = bus.sel_rd_i;
  assign bus8.alu_op_i   = bus.alu_op_i;
  assign bus8.alu_src1_i = bus.alu_src1_i;
  assign bus8.alu_src2_i = bus.alu_src2_i;
  assign bus8.mem_re_i   = bus.mem_re_i;
  assign bus8.mem_we_i   = bus.mem_we_i;
  assign bus8.mem_size_i = bus.mem_size_i;
  assign bus8.imm_i      = bus.imm_i;
  assign bus8.rs1_i      = bus.rs1_i;
  assign bus8.rs2_i      = bus.rs2_i;
  assign bus8.ready_i    = bus.ready_i;

`ifdef EXEC_STALL_CNT_EN
  logic [31:0] sc;
  logic [31:0] sc8;
`endif

  execute_pipe #(
    .XLEN(32), .STORE_HIST_DEPTH(4), .HIST_LIFETIME(3)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef EXEC_STALL_CNT_EN
    , .stall_cnt_o(sc)
`endif
  );

  execute_pipe #(
    .XLEN(32), .STORE_HIST_DEPTH(4), .HIST_LIFETIME(8)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8)
`ifdef EXEC_STALL_CNT_EN
    , .stall_cnt_o(sc8)
`endif
  );

  typedef struct {
    alu_op_e    op;
    alu_src_e   s1;
    alu_src_e   s2;
    logic       re;
    logic       we;
    data_size_e sz;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        re;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] rs2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[16];

  logic m_ready, m_hazard, m_valid, m_re, m_we;
  logic [4:0]  m_rd;
  logic [1:0]  m_size;
  logic [31:0] m_res, m_rs2;

  always_comb begin
    if (sel8) begin
      m_ready = bus8.ready_o;  m_hazard = bus8.hazard_o;
      m_valid = bus8.valid_o;  m_re = bus8.mem_re_o;
      m_we = bus8.mem_we_o;    m_rd = bus8.sel_rd_o;
      m_size = bus8.mem_size_o;
      m_res = bus8.alu_result_o; m_rs2 = bus8.rs2_o;
    end else begin
      m_ready = bus.ready_o;   m_hazard = bus.hazard_o;
      m_valid = bus.valid_o;   m_re = bus.mem_re_o;
      m_we = bus.mem_we_o;     m_rd = bus.sel_rd_o;
      m_size = bus.mem_size_o;
      m_res = bus.alu_result_o; m_rs2 = bus.rs2_o;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk_alu(alu_op_e op, alu_src_e s1,
      alu_src_e s2, logic [31:0] imm, logic [31:0] rs1,
      logic [31:0] rs2, logic [4:0] rd, logic [31:0] res);
    vec_t v;
    v.op = op; v.s1 = s1; v.s2 = s2;
    v.re = 1'b0; v.we = 1'b0; v.sz = SZ_WORD;
    v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.res = res;
    return v;
  endfunction

  function automatic vec_t mk_mem(logic re, logic we,
      data_size_e sz, logic [31:0] addr, logic [4:0] rd);
    vec_t v;
    v.op = ALU_ADD; v.s1 = SRC_RS1; v.s2 = SRC_IMM;
    v.re = re; v.we = we; v.sz = sz;
    v.imm = 32'd4; v.rs1 = addr - 32'd4;
    v.rs2 = addr ^ 32'h5A5A_0000;
    v.rd = rd; v.res = addr;
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    bus.alu_op_i   = v.op;
    bus.alu_src1_i = v.s1;
    bus.alu_src2_i = v.s2;
    bus.mem_re_i   = v.re;
    bus.mem_we_i   = v.we;
    bus.mem_size_i = v.sz;
    bus.imm_i      = v.imm;
    bus.rs1_i      = v.rs1;
    bus.rs2_i      = v.rs2;
    bus.sel_rd_i   = v.rd;
    bus.valid_i    = 1'b1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic drive(input vec_t v, output int waited,
                       output int hz);
    exp_t e;
    set_in(v);
    waited = 0;
    hz = 0;
    @(negedge clk);
    while (!m_ready && waited <= 40) begin
      if (m_hazard) hz++;
      waited++;
      @(negedge clk);
    end
    if (waited > 40) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout rd=%0d waited=%0d limit=40",
               v.rd, waited);
    end else begin
      e.rd = v.rd; e.res = v.res; e.re = v.re; e.we = v.we;
      e.sz = v.sz; e.rs2 = v.rs2;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && bus.ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected rd=%0d res=%0h want=none",
                 m_rd, m_res);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_result", m_res, mon_e.res);
        chk("sb_rd", m_rd, mon_e.rd);
        chk("sb_re", m_re, mon_e.re);
        chk("sb_we", m_we, mon_e.we);
        chk("sb_size", m_size, mon_e.sz);
        chk("sb_rs2", m_rs2, mon_e.rs2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h;
    vec_t v;
`ifdef EXEC_STALL_CNT_EN
    logic [31:0] sc0;
`endif
    tbl[0]  = mk_alu(ALU_ADD, SRC_RS1, SRC_RS2, 0, 5, 7, 1, 12);
    tbl[1]  = mk_alu(ALU_SUB, SRC_RS1, SRC_RS2, 0, 5, 7, 2,
                     32'hFFFF_FFFE);
    tbl[2]  = mk_alu(ALU_AND, SRC_RS1, SRC_IMM, 32'h0FF0,
                     32'hF0F0, 0, 3, 32'h00F0);
    tbl[3]  = mk_alu(ALU_OR, SRC_RS1, SRC_RS2, 0, 32'h1200,
                     32'h0034, 4, 32'h1234);
    tbl[4]  = mk_alu(ALU_XOR, SRC_RS1, SRC_IMM, 32'h0F0F_0F0F,
                     32'hFFFF_0000, 0, 5, 32'hF0F0_0F0F);
    tbl[5]  = mk_alu(ALU_SLL, SRC_RS1, SRC_IMM, 4, 1, 0, 6, 32'h10);
    tbl[6]  = mk_alu(ALU_SRL, SRC_RS1, SRC_IMM, 4, 32'h8000_0000,
                     0, 7, 32'h0800_0000);
    tbl[7]  = mk_alu(ALU_SRA, SRC_RS1, SRC_IMM, 4, 32'h8000_0000,
                     0, 8, 32'hF800_0000);
    tbl[8]  = mk_alu(ALU_SLT, SRC_RS1, SRC_RS2, 0, 32'hFFFF_FFFF,
                     1, 9, 1);
    tbl[9]  = mk_alu(ALU_SLTU, SRC_RS1, SRC_RS2, 0, 32'hFFFF_FFFF,
                     1, 10, 0);
    tbl[10] = mk_alu(ALU_ADD, SRC_ZERO, SRC_IMM, 32'h55, 9, 9, 11,
                     32'h55);
    tbl[11] = mk_alu(ALU_ADD, SRC_RS2, SRC_IMM, 32'h20, 0, 32'h10,
                     12, 32'h30);
    tbl[12] = mk_alu(ALU_ADD, SRC_IMM, SRC_IMM, 3, 0, 0, 13, 6);
    tbl[13] = mk_mem(1'b0, 1'b1, SZ_WORD, 32'h200, 0);
    tbl[14] = mk_mem(1'b1, 1'b0, SZ_BYTE, 32'h204, 14);
    tbl[15] = mk_mem(1'b1, 1'b0, SZ_WORD, 32'h1FC, 15);

    bus.valid_i = 0; bus.flush_i = 0; bus.ready_i = 1;
    bus.sel_rd_i = 0; bus.alu_op_i = ALU_ADD;
    bus.alu_src1_i = SRC_ZERO; bus.alu_src2_i = SRC_ZERO;
    bus.mem_re_i = 0; bus.mem_we_i = 0; bus.mem_size_i = SZ_BYTE;
    bus.imm_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_result", bus.alu_result_o, 0);
    chk("rst_size", bus.mem_size_o, 0);
    chk("rst_rd", bus.sel_rd_o, 0);
    chk("rst_hazard", bus.hazard_o, 0);
    chk("rst_ready", bus.ready_o, 1);
`ifdef EXEC_STALL_CNT_EN
    chk("rst_stall_cnt", sc, 0);
`endif
    @(posedge clk);
    #1;

    // single ADD: result one cycle after acceptance
    drive(tbl[0], w, h);
    chk("t1_wait", w, 0);
    chk("t1_valid", bus.valid_o, 1);
    chk("t1_result", bus.alu_result_o, 12);
    chk("t1_rd", bus.sel_rd_o, 1);
    idle(1);
    chk("t1_bubble", bus.valid_o, 0);

    for (int i = 1; i < 16; i++) begin
      drive(tbl[i], w, h);
      chk("tbl_wait", w, 0);
    end
    idle(4);

    // store then overlapping load
    drive(mk_mem(1'b0, 1'b1, SZ_WORD, 32'h100, 0), w, h);
    chk("t2_sw_wait", w, 0);
`ifdef EXEC_STALL_CNT_EN
    sc0 = sc;
`endif
    drive(mk_mem(1'b1, 1'b0, SZ_WORD, 32'h100, 5), w, h);
    chk("t2_lw_wait", w, 2);
    chk("t2_lw_hazard", h, 2);
    chk("t2_valid", bus.valid_o, 1);
    chk("t2_result", bus.alu_result_o, 32'h100);
`ifdef EXEC_STALL_CNT_EN
    chk("t2_stall_cnt", sc - sc0, 2);
`endif
    idle(4);

    drive(mk_mem(1'b0, 1'b1, SZ_BYTE, 32'h103, 0), w, h);
    drive(mk_mem(1'b1, 1'b0, SZ_HALF, 32'h102, 6), w, h);
    chk("t3_lh_ovl_wait", w, 2);
    idle(4);
    drive(mk_mem(1'b0, 1'b1, SZ_BYTE, 32'h103, 0), w, h);
    drive(mk_mem(1'b1, 1'b0, SZ_HALF, 32'h100, 7), w, h);
    chk("t3_lh_disj_wait", w, 0);
    idle(4);
    drive(mk_mem(1'b0, 1'b1, SZ_WORD, 32'hFFFF_FFFF, 0), w, h);
    drive(mk_mem(1'b1, 1'b0, SZ_BYTE, 32'h0, 8), w, h);
    chk("t3_nowrap_wait", w, 0);
    idle(4);

    // backpressure holds outputs stable
    bus.ready_i = 1'b0;
    drive(mk_alu(ALU_ADD, SRC_RS1, SRC_RS2, 0, 9, 4, 20, 13), w, h);
    set_in(mk_alu(ALU_XOR, SRC_RS1, SRC_RS2, 0, 1, 2, 21, 3));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.valid_o, 1);
      chk("t5_hold_result", bus.alu_result_o, 13);
      chk("t5_hold_rd", bus.sel_rd_o, 20);
      chk("t5_hold_ready", bus.ready_o, 0);
    end
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    drive(mk_mem(1'b0, 1'b1, SZ_WORD, 32'h300, 0), w, h);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    chk("t5_flush_valid", bus.valid_o, 0);
    chk("t5_flush_q", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    bus.ready_i = 1'b1;
    drive(mk_mem(1'b1, 1'b0, SZ_WORD, 32'h300, 22), w, h);
    chk("t5_post_flush_wait", w, 1);
    chk("t5_post_flush_hz", h, 1);
    idle(4);

    // reset while a load is held
    drive(mk_mem(1'b0, 1'b1, SZ_WORD, 32'h400, 0), w, h);
    v = mk_mem(1'b1, 1'b0, SZ_WORD, 32'h400, 23);
    set_in(v);
    @(negedge clk);
    chk("t6_pre_hazard", bus.hazard_o, 1);
    chk("t6_pre_ready", bus.ready_o, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.valid_o, 0);
    chk("t6_rst_result", bus.alu_result_o, 0);
    chk("t6_rst_size", bus.mem_size_o, 0);
    chk("t6_rst_we", bus.mem_we_o, 0);
    chk("t6_rst_hazard", bus.hazard_o, 0);
    chk("t6_rst_ready", bus.ready_o, 1);
`ifdef EXEC_STALL_CNT_EN
    chk("t6_rst_stall_cnt", sc, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(v, w, h);
    chk("t6_reissue_wait", w, 0);
    idle(3);

    // depth 4, lifetime 8: fifth store waits for entry 0
    do_reset();
    sel8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(mk_mem(1'b0, 1'b1, SZ_WORD,
                   32'h1000 + 32'(i) * 32'h10, 0), w, h);
      chk("t4_store_wait", w, (i == 4) ? 4 : 0);
      chk("t4_store_hz", h, 0);
    end
    drive(mk_mem(1'b0, 1'b1, SZ_WORD, 32'h1050, 0), w, h);
    chk("t4_wrap_wait", w, 0);
    drive(mk_mem(1'b1, 1'b0, SZ_WORD, 32'h1040, 24), w, h);
    chk("t4_wrap_load_wait", w, 6);
    chk("t4_wrap_load_hz", h, 6);
    idle(4);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
